pio_shift_out_serializer: RTL

//  Consumes the parallel output word of the Avalon PIO output port and drives external

---
 rtl/pio_shift_out_serializer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pio_shift_out_serializer.sv
// Serializes the PIO parallel output word into a daisy-chained 74HC595-style shift register chain.
// A frame is sent when the word differs from the last latched frame, on request, or once after reset.
module pio_shift_out_serializer #(
  parameter int DATA_W    = 21,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] par_in,
  input  logic              force_update,
  output logic              sr_sck,
  output logic              sr_sdo,
  output logic              sr_rck,
  output logic              sr_oe_n,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int IDX_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   last_sent, last_sent_nxt;
  logic [DATA_W-1:0]   shadow;
  logic                pend, pend_nxt;
  logic [IDX_W-1:0]    bit_idx, bit_idx_nxt;
  logic [DIV_W-1:0]    div, div_nxt;
  logic                sck_nxt, sdo_nxt, rck_nxt, oe_n_nxt, busy_nxt;
  logic [15:0]         cnt_nxt;
  logic                start;
  logic                load_shadow;
  logic                div_done;

  function automatic logic pick_bit(input logic [DATA_W-1:0] word,
                                    input logic [IDX_W-1:0]  idx);
    logic [IDX_W-1:0]  pos;
    logic [DATA_W-1:0] sh;
    pos = (MSB_FIRST != 0) ? (IDX_W'(DATA_W - 1) - idx) : idx;
    sh  = word >> pos;
    return sh[0];
  endfunction

  assign start    = (par_in != last_sent) | pend | force_update;
  assign div_done = (div == DIV_W'(CLK_DIV - 1));

  always_comb begin
    state_nxt     = state;
    pend_nxt      = pend;
    bit_idx_nxt   = bit_idx;
    div_nxt       = div;
    sck_nxt       = sr_sck;
    sdo_nxt       = sr_sdo;
    rck_nxt       = sr_rck;
    oe_n_nxt      = sr_oe_n;
    busy_nxt      = busy;
    cnt_nxt       = frame_cnt;
    last_sent_nxt = last_sent;
    load_shadow   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_shadow = 1'b1;
          pend_nxt    = 1'b0;
          bit_idx_nxt = '0;
          div_nxt     = '0;
          sdo_nxt     = pick_bit(par_in, '0);
          sck_nxt     = 1'b0;
          busy_nxt    = 1'b1;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (div_done) begin
          div_nxt = '0;
          if (!sr_sck) begin
            sck_nxt = 1'b1;
          end else begin
            // Falling SCK edge: either advance to the next bit or finish the frame.
            sck_nxt = 1'b0;
            if (bit_idx == IDX_W'(DATA_W - 1)) begin
              rck_nxt   = 1'b1;
              state_nxt = LATCH;
            end else begin
              bit_idx_nxt = bit_idx + IDX_W'(1);
              sdo_nxt     = pick_bit(shadow, bit_idx + IDX_W'(1));
            end
          end
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      LATCH: begin
        if (div_done) begin
          div_nxt       = '0;
          rck_nxt       = 1'b0;
          last_sent_nxt = shadow;
          oe_n_nxt      = 1'b0;
          cnt_nxt       = frame_cnt + 16'd1;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pend      <= 1'b1;
      bit_idx   <= '0;
      div       <= '0;
      sr_sck    <= 1'b0;
      sr_sdo    <= 1'b0;
      sr_rck    <= 1'b0;
      sr_oe_n   <= 1'b1;
      busy      <= 1'b0;
      frame_cnt <= 16'd0;
      last_sent <= '0;
    end else begin
      state     <= state_nxt;
      pend      <= pend_nxt;
      bit_idx   <= bit_idx_nxt;
      div       <= div_nxt;
      sr_sck    <= sck_nxt;
      sr_sdo    <= sdo_nxt;
      sr_rck    <= rck_nxt;
      sr_oe_n   <= oe_n_nxt;
      busy      <= busy_nxt;
      frame_cnt <= cnt_nxt;
      last_sent <= last_sent_nxt;
    end
  end

  // Frame capture register; only meaningful while a frame is in flight.
  always_ff @(posedge clk) begin
    if (load_shadow) shadow <= par_in;
  end

endmodule
